cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_multicycle.sv | 187 ++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: accumulator CPU with a FETCH/DECODE/OPFETCH/EXEC/HALT sequencer
// over a req/ready memory port. Define CPU_CARRY_EN to enable flag_c and the JC opcode.
module cpu_multicycle #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_z,
    output logic              flag_c,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_OPFETCH = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JEZ = 4'd7;
    localparam logic [3:0] OP_JNZ = 4'd8;
    localparam logic [3:0] OP_LDI = 4'd9;
`ifdef CPU_CARRY_EN
    localparam logic [3:0] OP_JC  = 4'd10;
`endif
    localparam logic [3:0] OP_HLT = 4'd15;

    logic [2:0]        state;
    logic [3:0]        ir;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] acc;
    logic              boot;
    logic              needs_operand;
    logic              mem_op;
    logic              mem_done;
    logic [ADDR_W-1:0] op_addr;

`ifdef CPU_CARRY_EN
    logic carry;
    assign flag_c = carry;
`else
    assign flag_c = 1'b0;
`endif

    assign op_addr   = operand[ADDR_W-1:0];
    assign flag_z    = (acc == '0);
    assign halted    = (state == S_HALT);
    assign state_dbg = state;
    assign mem_op    = (ir == OP_LDA) || (ir == OP_ADD) || (ir == OP_SUB) || (ir == OP_STA);

    always_comb begin
        needs_operand = 1'b0;
        case (ir)
            OP_LDA, OP_ADD, OP_SUB, OP_STA,
            OP_JMP, OP_JEZ, OP_JNZ, OP_LDI: needs_operand = 1'b1;
`ifdef CPU_CARRY_EN
            OP_JC:                          needs_operand = 1'b1;
`endif
            default:                        needs_operand = 1'b0;
        endcase
    end

    // Memory handshake: a transfer is offered while mem_req=1 and completes at the
    // rising edge where mem_ready=1; until then req/we/addr/wdata hold steady because
    // they depend only on state, ir, operand, pc and acc, none of which move while waiting.
    // The first cycle after reset (boot) issues no request.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = acc;
        case (state)
            S_FETCH:   mem_req = !boot;
            S_OPFETCH: mem_req = 1'b1;
            S_EXEC: begin
                if (mem_op) begin
                    mem_req  = 1'b1;
                    mem_we   = (ir == OP_STA);
                    mem_addr = op_addr;
                end
            end
            default: mem_req = 1'b0;
        endcase
    end

    assign mem_done = mem_req && mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= '0;
            acc       <= '0;
            ir        <= '0;
            operand   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            boot      <= 1'b1;
`ifdef CPU_CARRY_EN
            carry     <= 1'b0;
`endif
        end else begin
            boot      <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_done) begin
                        ir    <= mem_rdata[3:0];
                        pc    <= pc + ADDR_W'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (ir == OP_HLT) begin
                        state <= S_HALT;
                    end else if (needs_operand) begin
                        state <= S_OPFETCH;
                    end else begin
                        if (ir == OP_OUT) begin
                            out_valid <= 1'b1;
                            out_data  <= acc;
                        end
                        state <= S_FETCH;
                    end
                end
                S_OPFETCH: begin
                    if (mem_done) begin
                        operand <= mem_rdata;
                        pc      <= pc + ADDR_W'(1);
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (mem_op) begin
                        if (mem_done) begin
                            case (ir)
                                OP_LDA: acc <= mem_rdata;
`ifdef CPU_CARRY_EN
                                OP_ADD: {carry, acc} <= {1'b0, acc} + {1'b0, mem_rdata};
                                OP_SUB: begin
                                    carry <= (acc < mem_rdata);
                                    acc   <= acc - mem_rdata;
                                end
`else
                                OP_ADD: acc <= acc + mem_rdata;
                                OP_SUB: acc <= acc - mem_rdata;
`endif
                                default: ;
                            endcase
                            state <= S_FETCH;
                        end
                    end else begin
                        case (ir)
                            OP_LDI: acc <= operand;
                            OP_JMP: pc <= op_addr;
                            OP_JEZ: if (flag_z) pc <= op_addr;
                            OP_JNZ: if (!flag_z) pc <= op_addr;
`ifdef CPU_CARRY_EN
                            OP_JC:  if (carry) pc <= op_addr;
`endif
                            default: ;
                        endcase
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: directed program table, hand-written reset/wait-state
// sequences, and random programs checked against an instruction-level interpreter.
`timescale 1ns/1ps
module tb_cpu_multicycle;

    localparam int DW = 8;
    localparam int AW = 8;
`ifdef CPU_CARRY_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif
    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_OPFETCH = 3'd2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid, halted, flag_z, flag_c;
    logic [AW-1:0] pc;
    logic [2:0]    state_dbg;

    cpu_multicycle #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .out_data(out_data), .out_valid(out_valid), .halted(halted), .pc(pc),
        .flag_z(flag_z), .flag_c(flag_c), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [7:0] mem [0:255];
    int         ready_pct = 100;
    bit         stall_all = 1'b0;
    int         wr_stall  = 0;
    int         wr_count  = 0;
    logic [7:0] out_q[$];
    bit         rst_seen = 1'b0;
    bit         prev_wait = 1'b0;
    logic       prev_we;
    logic [7:0] prev_addr, prev_wdata;

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (prev_wait && !rst_seen)
            chk("req_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                {1'b1, prev_we, prev_addr, prev_wdata});
        if (stall_all) begin
            mem_ready = 1'b0;
        end else if (mem_req && mem_we && wr_stall > 0) begin
            mem_ready = 1'b0;
            wr_stall--;
        end else begin
            mem_ready = ($urandom_range(1, 100) <= ready_pct);
        end
        mem_rdata = mem_ready ? mem[mem_addr] : 8'($urandom);
        if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_count++;
        end
        if (out_valid) out_q.push_back(out_data);
        prev_wait  = mem_req && !mem_ready;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        out_q.delete();
        wr_count = 0;
        reset = 1'b0;
    endtask

    task automatic run_dut(input int budget, output int cyc, output bit done);
        cyc  = 0;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (halted) begin
                done = 1'b1;
                break;
            end
            cyc++;
        end
    endtask

    // ---------------- reference interpreter ----------------
    logic [7:0] m_mem [0:255];
    logic [7:0] m_out[$];
    logic [7:0] m_pc, m_a;
    bit         m_c, m_halt;
    int         m_wr, m_cyc;

    function automatic bit has_operand(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd6 && op <= 4'd9) ||
               (op == 4'd10 && CARRY_EN);
    endfunction

    task automatic run_model();
        logic [7:0] w, opnd, m;
        logic [3:0] op;
        logic [8:0] sum;
        m_mem = mem;
        m_pc = 0; m_a = 0; m_c = 0; m_wr = 0; m_cyc = 0; m_halt = 0;
        m_out.delete();
        for (int n = 0; n < 2000 && !m_halt; n++) begin
            w = m_mem[m_pc]; op = w[3:0]; m_pc++;
            if (op == 4'hF) begin
                m_cyc += 2; m_halt = 1;
            end else if (!has_operand(op)) begin
                m_cyc += 2;
                if (op == 4'd5) m_out.push_back(m_a);
            end else begin
                opnd = m_mem[m_pc]; m_pc++; m_cyc += 4;
                m = m_mem[opnd];
                case (op)
                    4'd1: m_a = m;
                    4'd2: begin
                        sum = {1'b0, m_a} + {1'b0, m};
                        if (CARRY_EN) m_c = sum[8];
                        m_a = sum[7:0];
                    end
                    4'd3: begin
                        if (CARRY_EN) m_c = (m_a < m);
                        m_a = m_a - m;
                    end
                    4'd4: begin m_mem[opnd] = m_a; m_wr++; end
                    4'd6: m_pc = opnd;
                    4'd7: if (m_a == 0) m_pc = opnd;
                    4'd8: if (m_a != 0) m_pc = opnd;
                    4'd9: m_a = opnd;
                    4'd10: if (m_c) m_pc = opnd;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic gen_random();
        int p;
        logic [3:0] op;
        for (int i = 0; i < 256; i++) mem[i] = (i >= 128) ? 8'($urandom) : 8'h0F;
        p = 0;
        while (p < 8'h60) begin
            op = 4'($urandom_range(0, 14));
            mem[p] = {4'($urandom), op};
            p++;
            if (op inside {[4'd1:4'd4], [4'd6:4'd10]}) begin
                if (op inside {[4'd1:4'd4]}) mem[p] = 8'($urandom_range(128, 255));
                else if (op == 4'd9)        mem[p] = 8'($urandom);
                else                        mem[p] = 8'($urandom_range(p + 1, 8'h62));
                p++;
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string      name;
        int         wr_wait;
        int         nout;
        logic [7:0] last;
        logic [7:0] epc;
        bit         z;
        bit         c;
        int         cyc;
        int         wr;
        logic [7:0] caddr;
        logic [7:0] cval;
    } tv_t;

    typedef struct {
        int         t;
        logic [7:0] a;
        logic [7:0] v;
    } img_t;

    tv_t  tv[7];
    img_t img[$];

    task automatic prog(input int t, input logic [7:0] base, input logic [63:0] words, input int n);
        for (int k = 0; k < n; k++) img.push_back('{t, base + 8'(k), words[63-8*k -: 8]});
    endtask

    initial begin
        int cyc, diffs;
        bit done;

        // name, wr_wait, nout, last, pc, z, c, cycles, writes, check addr, check value
        tv[0] = '{"ldi_add_out", 0, 1, 8'h08, 8'h06, 0, 0, 12, 0, 8'h20, 8'h03};
        prog(0, 8'h00, 64'h09_05_02_20_05_0F_00_00, 6);  prog(0, 8'h20, 64'h03 << 56, 1);
        tv[1] = '{"sub_jnz_loop", 0, 1, 8'h00, 8'h08, 1, 0, 32, 0, 8'h21, 8'h01};
        prog(1, 8'h00, 64'h09_03_03_21_08_02_05_0F, 8);  prog(1, 8'h21, 64'h01 << 56, 1);
        tv[2] = '{"sta_wait3", 3, 0, 8'h00, 8'h05, 0, 0, 13, 1, 8'h40, 8'h5A};
        prog(2, 8'h00, 64'h09_5A_04_40_0F_00_00_00, 5);
        tv[3] = '{"pc_wrap", 0, 1, 8'h07, 8'h04, 0, 0, 22, 0, 8'hFF, 8'h00};
        prog(3, 8'h00, 64'h07_10_05_0F_00_00_00_00, 4);  prog(3, 8'h10, 64'h09_07_06_FF_00_00_00_00, 4);
        if (CARRY_EN) tv[4] = '{"add_carry_jc", 0, 2, 8'h11, 8'h34, 0, 1, 22, 0, 8'h22, 8'h02};
        else          tv[4] = '{"add_carry_jc", 0, 1, 8'h01, 8'h08, 0, 0, 16, 0, 8'h22, 8'h02};
        prog(4, 8'h00, 64'h09_FF_02_22_05_0A_30_0F, 8);  prog(4, 8'h22, 64'h02 << 56, 1);
        prog(4, 8'h30, 64'h09_11_05_0F_00_00_00_00, 4);
        tv[5] = '{"sub_borrow", 0, 1, 8'hFF, 8'h06, 0, CARRY_EN, 12, 0, 8'h23, 8'h02};
        prog(5, 8'h00, 64'h09_01_03_23_05_0F_00_00, 6);  prog(5, 8'h23, 64'h02 << 56, 1);
        tv[6] = '{"lda_sta_nop", 0, 2, 8'h00, 8'h0C, 1, 0, 24, 1, 8'h41, 8'h3C};
        prog(6, 8'h00, 64'h01_24_0B_04_41_01_41_05, 8);  prog(6, 8'h08, 64'h09_00_05_0F_00_00_00_00, 4);
        prog(6, 8'h24, 64'h3C << 56, 1);

        // reset state
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {flag_z, flag_c}, 2'b10);
        chk("rst_halted", halted, 0);
        chk("rst_state", state_dbg, ST_FETCH);

        // table-driven programs
        for (int i = 0; i < 7; i++) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'h00;
            foreach (img[j]) if (img[j].t == i) mem[img[j].a] = img[j].v;
            ready_pct = 100;
            wr_stall  = tv[i].wr_wait;
            do_reset();
            run_dut(400, cyc, done);
            chk({tv[i].name, "_done"}, done, 1);
            chk({tv[i].name, "_nout"}, out_q.size(), tv[i].nout);
            if (tv[i].nout > 0 && out_q.size() > 0)
                chk({tv[i].name, "_out"}, out_q[out_q.size()-1], tv[i].last);
            chk({tv[i].name, "_pc"}, pc, tv[i].epc);
            chk({tv[i].name, "_z"}, flag_z, tv[i].z);
            chk({tv[i].name, "_c"}, flag_c, tv[i].c);
            chk({tv[i].name, "_cycles"}, cyc, tv[i].cyc);
            chk({tv[i].name, "_writes"}, wr_count, tv[i].wr);
            chk({tv[i].name, "_memval"}, mem[tv[i].caddr], tv[i].cval);
            repeat (2) @(negedge clk);
            #1 chk({tv[i].name, "_halt_idle"}, {halted, mem_req}, 2'b10);
        end

        // reset while stalled in OPFETCH
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[0] = 8'h09; mem[1] = 8'h44; mem[2] = 8'h09; mem[3] = 8'h55; mem[4] = 8'h0F;
        ready_pct = 100;
        wr_stall  = 0;
        do_reset();
        repeat (6) @(negedge clk);
        #1 stall_all = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("opf_wait_state", state_dbg, ST_OPFETCH);
        chk("opf_wait_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h03});
        chk("opf_wait_a", flag_z, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("opf_rst_req", mem_req, 0);
        chk("opf_rst_pc", pc, 0);
        chk("opf_rst_a", flag_z, 1);
        chk("opf_rst_state", state_dbg, ST_FETCH);
        stall_all = 1'b0;
        reset = 1'b0;
        run_dut(100, cyc, done);
        chk("opf_rerun_done", {done, pc}, {1'b1, 8'h05});
        chk("opf_rerun_cycles", cyc, 10);

        // random programs against the interpreter
        for (int r = 0; r < 20; r++) begin
            for (int tries = 0; tries < 10; tries++) begin
                gen_random();
                run_model();
                if (m_halt) break;
            end
            if (!m_halt) continue;
            ready_pct = (r % 3 == 0) ? 100 : $urandom_range(40, 99);
            do_reset();
            run_dut(5000, cyc, done);
            chk("rand_done", done, 1);
            chk("rand_nout", out_q.size(), m_out.size());
            for (int k = 0; k < out_q.size() && k < m_out.size(); k++) chk("rand_out", out_q[k], m_out[k]);
            chk("rand_pc", pc, m_pc);
            chk("rand_z", flag_z, (m_a == 0));
            chk("rand_c", flag_c, m_c);
            chk("rand_writes", wr_count, m_wr);
            diffs = 0;
            for (int a = 0; a < 256; a++) if (mem[a] !== m_mem[a]) diffs++;
            chk("rand_mem_diffs", diffs, 0);
            if (ready_pct == 100) chk("rand_cycles", cyc, m_cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
